debug_send_unit: RTL and testbench

- Responder to the debug FSM's start-send/done-send handshake: on `is_start_send`, dumps a snapshot of halted-pipeline state to the UART transmitter, then pulses `os_done_send`.
- Frame order: header byte, PC, clock count, 32 register-file words, N_MEM_WORDS data-memory words, each word LSB first.
- Sits between the debug FSM, the register file and data memory debug read ports, and the UART TX byte interface.

---
 rtl/debug_send_unit.sv | 139 +++++++++++++
 tb/tb_debug_send_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_send_unit.sv
// Debug snapshot sender: on a start pulse, streams a header byte followed by PC,
// cycle count, register file and data memory words (LSB first) to a UART TX.
module debug_send_unit #(
  parameter int          N_MEM_WORDS = 32,
  parameter int          MEM_ADDR_W  = 5,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_start_send,
  input  logic [31:0]           i_pc,
  input  logic [31:0]           i_clk_count,
  output logic [4:0]            o_reg_addr,
  input  logic [31:0]           i_reg_data,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]           i_mem_data,
  output logic [7:0]            o_tx_data,
  output logic                  os_tx_start,
  input  logic                  is_tx_done,
  output logic                  os_done_send,
  output logic                  o_busy
);

  localparam int W  = 34 + N_MEM_WORDS;
  localparam int WW = $clog2(W + 1);

  localparam logic [WW-1:0] W_PC      = WW'(0);
  localparam logic [WW-1:0] W_CNT     = WW'(1);
  localparam logic [WW-1:0] W_REG_LO  = WW'(2);
  localparam logic [WW-1:0] W_REG_HI  = WW'(33);
  localparam logic [WW-1:0] W_MEM_LO  = WW'(34);
  localparam logic [WW-1:0] W_LAST    = WW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_HDR_WAIT, S_FETCH, S_LATCH, S_SEND, S_WAIT, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] w_q, w_d;
  logic [1:0]    b_q, b_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   sh_q, sh_d;
  logic [31:0]   word_sel;

  // NOTE: sequential state uses non-blocking assignments only; combinational
  // blocks use blocking assignments, so each flop sees last-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      b_q     <= b_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

  // Source of the word being loaded: snapshots first, then the two read ports.
  always_comb begin
    word_sel = i_mem_data;
    if (w_q == W_PC)           word_sel = pc_q;
    else if (w_q == W_CNT)     word_sel = cnt_q;
    else if (w_q <= W_REG_HI)  word_sel = i_reg_data;
  end

  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    b_d     = b_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: begin
        if (is_start_send) begin
          pc_d    = i_pc;
          cnt_d   = i_clk_count;
          w_d     = '0;
          state_d = S_HDR;
        end
      end
      S_HDR:      state_d = S_HDR_WAIT;
      S_HDR_WAIT: if (is_tx_done) state_d = S_FETCH;
      S_FETCH:    state_d = S_LATCH;
      S_LATCH: begin
        sh_d    = word_sel;
        b_d     = '0;
        state_d = S_SEND;
      end
      S_SEND:     state_d = S_WAIT;
      S_WAIT: begin
        if (is_tx_done) begin
          if (b_q != 2'd3) begin
            b_d     = b_q + 2'd1;
            state_d = S_SEND;
          end else if (w_q != W_LAST) begin
            w_d     = w_q + WW'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_data    = 8'h00;
    os_tx_start  = 1'b0;
    os_done_send = 1'b0;
    o_busy       = (state_q != S_IDLE);
    o_reg_addr   = 5'd0;
    o_mem_addr   = '0;
    case (state_q)
      S_HDR:      begin o_tx_data = HEADER; os_tx_start = 1'b1; end
      S_HDR_WAIT: o_tx_data = HEADER;
      S_SEND:     begin o_tx_data = sh_q[{b_q, 3'b000} +: 8]; os_tx_start = 1'b1; end
      S_WAIT:     o_tx_data = sh_q[{b_q, 3'b000} +: 8];
      S_DONE:     os_done_send = 1'b1;
      default:    ;
    endcase
    // Read addresses are a pure function of the word index.
    if (w_q >= W_REG_LO && w_q <= W_REG_HI) o_reg_addr = 5'(w_q - W_REG_LO);
    if (w_q >= W_MEM_LO)                    o_mem_addr = MEM_ADDR_W'(w_q - W_MEM_LO);
  end

endmodule

// File: tb/tb_debug_send_unit.sv
// Directed bench for debug_send_unit: TX model acknowledges each byte 3 cycles
// after launch; frames are compared against a locally built byte stream.
module tb_debug_send_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_start_send = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_clk_count = '0;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data = '0;
  logic [4:0]  o_mem_addr;
  logic [31:0] i_mem_data = '0;
  logic [7:0]  o_tx_data;
  logic        os_tx_start;
  logic        is_tx_done;
  logic        os_done_send;
  logic        o_busy;

  logic tx_done_model = 1'b0;
  logic tx_done_force = 1'b0;
  assign is_tx_done = tx_done_model | tx_done_force;

  debug_send_unit #(.N_MEM_WORDS(32), .MEM_ADDR_W(5), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .is_start_send(is_start_send),
    .i_pc(i_pc), .i_clk_count(i_clk_count),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_tx_data(o_tx_data), .os_tx_start(os_tx_start), .is_tx_done(is_tx_done),
    .os_done_send(os_done_send), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read register file and data memory with known contents.
  always @(posedge clk) begin
    i_reg_data <= 32'(o_reg_addr) * 32'h0101_0101;
    i_mem_data <= 32'hDEAD_0000 + 32'(o_mem_addr);
  end

  // UART TX model: done pulse 3 cycles after each launch.
  int tx_cnt = 0;
  always @(negedge clk) begin
    tx_done_model = 1'b0;
    if (os_tx_start) tx_cnt = 3;
    else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done_model = 1'b1;
    end
  end

  // Recorder of launched bytes, their cycles, and completion events.
  logic [7:0]  bytes_q[$];
  int          cyc_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        busy_at_done = 1'b0;
  logic        busy_after_done = 1'b1;
  logic        prev_done = 1'b0;
  logic [31:0] reg_seen = '0;
  logic [31:0] mem_seen = '0;
  always @(negedge clk) begin
    if (os_tx_start) begin
      bytes_q.push_back(o_tx_data);
      cyc_q.push_back(cyc);
    end
    if (os_done_send) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = o_busy;
    end
    if (prev_done) busy_after_done = o_busy;
    prev_done = os_done_send;
    reg_seen[o_reg_addr] = 1'b1;
    mem_seen[o_mem_addr] = 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec();
    bytes_q.delete();
    cyc_q.delete();
    done_cnt        = 0;
    busy_at_done    = 1'b0;
    busy_after_done = 1'b1;
    reg_seen        = '0;
    mem_seen        = '0;
  endtask

  task automatic push_word(input logic [31:0] wd);
    for (int k = 0; k < 4; k++) exp_q.push_back(wd[8*k +: 8]);
  endtask

  task automatic build_expected(input logic [31:0] pc, input logic [31:0] cnt);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    push_word(pc);
    push_word(cnt);
    for (int i = 0; i < 32; i++) push_word(32'(i) * 32'h0101_0101);
    for (int j = 0; j < 32; j++) push_word(32'hDEAD_0000 + 32'(j));
  endtask

  task automatic pulse_start(input logic [31:0] pc, input logic [31:0] cnt, output int sc);
    i_pc          = pc;
    i_clk_count   = cnt;
    is_start_send = 1'b1;
    sc            = cyc;
    step();
    is_start_send = 1'b0;
  endtask

  task automatic wait_bytes(input string name, input int n);
    int t = 0;
    while (bytes_q.size() < n && t < 3000) begin step(); t++; end
    n_cmp++;
    if (bytes_q.size() < n) begin
      n_bad++;
      $display("FAIL %s: byte count %0d after timeout, required >= %0d", name, bytes_q.size(), n);
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin step(); t++; end
    n_cmp++;
    if (done_cnt == 0) begin
      n_bad++;
      $display("FAIL %s: os_done_send timeout, bytes sent %0d", name, bytes_q.size());
    end
    step();
    step();
  endtask

  task automatic verify_frame(input string name, input int start_cyc);
    int n;
    int gap_exp;
    n = bytes_q.size();
    n_cmp++;
    if (n !== 265) begin
      n_bad++;
      $display("FAIL %s frame_len: got %0d bytes, required 265", name, n);
    end
    for (int i = 0; i < n && i < 265; i++) begin
      n_cmp++;
      if (bytes_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s byte[%0d]: got %02h, required %02h", name, i, bytes_q[i], exp_q[i]);
      end
    end
    if (n > 0) begin
      n_cmp++;
      if (cyc_q[0] !== start_cyc + 1) begin
        n_bad++;
        $display("FAIL %s hdr_latency: header in cycle %0d, required %0d", name, cyc_q[0], start_cyc + 1);
      end
      for (int i = 1; i < n; i++) begin
        gap_exp = ((i - 1) % 4 == 0) ? 6 : 4;
        n_cmp++;
        if (cyc_q[i] - cyc_q[i-1] !== gap_exp) begin
          n_bad++;
          $display("FAIL %s gap[%0d]: got %0d cycles, required %0d", name, i, cyc_q[i] - cyc_q[i-1], gap_exp);
        end
      end
      n_cmp++;
      if (done_cyc !== cyc_q[n-1] + 4) begin
        n_bad++;
        $display("FAIL %s done_latency: done in cycle %0d, required %0d", name, done_cyc, cyc_q[n-1] + 4);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++;
      $display("FAIL %s done_count: got %0d, required 1", name, done_cnt);
    end
    n_cmp++;
    if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_fall: at done %b after %b, required 1 then 0", name, busy_at_done, busy_after_done);
    end
    n_cmp++;
    if (reg_seen !== 32'hFFFF_FFFF || mem_seen !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL %s addr_sweep: reg %08h mem %08h, required ffffffff both", name, reg_seen, mem_seen);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if ({o_tx_data, os_tx_start, os_done_send, o_busy, o_reg_addr, o_mem_addr} !== '0) begin
      n_bad++;
      $display("FAIL %s outputs: tx_data %02h start %b done %b busy %b reg %0d mem %0d, required all 0",
               name, o_tx_data, os_tx_start, os_done_send, o_busy, o_reg_addr, o_mem_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();
    check_idle_outputs("post_reset");
  endtask

  task automatic test_idle_spurious_done();
    clear_rec();
    tx_done_force = 1'b1;
    step();
    tx_done_force = 1'b0;
    repeat (6) step();
    n_cmp++;
    if (bytes_q.size() !== 0 || done_cnt !== 0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_spurious: bytes %0d done %0d busy %b, required 0 0 0", bytes_q.size(), done_cnt, o_busy);
    end
  endtask

  task automatic test_frame_snapshot_and_restart_ignore();
    int sc;
    clear_rec();
    pulse_start(32'h0000_0040, 32'h0000_0123, sc);
    wait_bytes("frame1_pc", 3);
    i_pc        = 32'hFFFF_FFFF;
    i_clk_count = 32'h0000_0000;
    wait_bytes("frame1_mid", 100);
    is_start_send = 1'b1;
    step();
    is_start_send = 1'b0;
    wait_done("frame1");
    build_expected(32'h0000_0040, 32'h0000_0123);
    verify_frame("frame1", sc);
  endtask

  task automatic test_back_to_back();
    int sc;
    clear_rec();
    pulse_start(32'h1234_5678, 32'hCAFE_BABE, sc);
    wait_done("frame2");
    build_expected(32'h1234_5678, 32'hCAFE_BABE);
    verify_frame("frame2", sc);
  endtask

  task automatic test_reset_mid_frame();
    int sc;
    int n_before;
    clear_rec();
    pulse_start(32'hA0A0_A0A0, 32'h0000_0055, sc);
    wait_bytes("abort_byte50", 51);
    step();
    rst = 1'b1;
    step();
    check_idle_outputs("abort_reset");
    rst = 1'b0;
    n_before = bytes_q.size();
    repeat (300) step();
    n_cmp++;
    if (done_cnt !== 0 || bytes_q.size() !== n_before) begin
      n_bad++;
      $display("FAIL abort_quiet: done %0d bytes %0d, required 0 and %0d", done_cnt, bytes_q.size(), n_before);
    end
    clear_rec();
    pulse_start(32'h0000_0040, 32'h0000_0123, sc);
    wait_done("frame3");
    build_expected(32'h0000_0040, 32'h0000_0123);
    verify_frame("frame3", sc);
  endtask

  initial begin
    test_reset();
    test_idle_spurious_done();
    test_frame_snapshot_and_restart_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
